// File: rtl/prog_loader.sv
// Byte-stream program loader: takes a length header and big-endian words and
// writes them into CPU memory from word 0, holding the CPU in reset until done.
module prog_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_WORDS  = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    // state   | meaning
    // IDLE    | out of reset, waiting for start
    // LEN_HI  | taking the length MSB
    // LEN_LO  | taking the length LSB, then validating the length
    // DATA    | assembling a word, four bytes MSB first
    // WRITE   | one-cycle memory write of the assembled word
    // DONE    | image complete, CPU released
    // ERROR   | length rejected, CPU held
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE, S_ERROR
    } state_t;

    localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

    state_t      state, state_nx;
    logic [15:0] len;
    logic [15:0] count;
    logic [1:0]  byte_idx;
    logic        accept;
    logic [15:0] len_full;
    logic        len_bad;
    logic        last_word;

    assign accept    = byte_valid && byte_ready;
    assign len_full  = {len[15:8], byte_data};
    assign len_bad   = (len_full == 16'd0) || ({1'b0, len_full} > MAX_LEN);
    assign last_word = ((count + 16'd1) == len);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start) state_nx = S_LEN_HI;
            S_LEN_HI: if (accept) state_nx = S_LEN_LO;
            S_LEN_LO: if (accept) state_nx = len_bad ? S_ERROR : S_DATA;
            S_DATA:   if (accept && byte_idx == 2'd3) state_nx = S_WRITE;
            S_WRITE:  state_nx = last_word ? S_DONE : S_DATA;
            S_DONE:   if (start) state_nx = S_LEN_HI;
            S_ERROR:  if (start) state_nx = S_LEN_HI;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Outputs depend on the registered state only, never on start/byte_valid.
    always_comb begin
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        cpu_hold   = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        case (state)
            S_LEN_HI, S_LEN_LO, S_DATA: byte_ready = 1'b1;
            S_WRITE:                    mem_we     = 1'b1;
            S_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            S_ERROR:                    error      = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len       <= 16'd0;
            count     <= 16'd0;
            byte_idx  <= 2'd0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
        end else begin
            case (state)
                S_LEN_HI: if (accept) len[15:8] <= byte_data;
                S_LEN_LO: if (accept) begin
                    len[7:0] <= byte_data;
                    count    <= 16'd0;
                    byte_idx <= 2'd0;
                    mem_addr <= '0;
                end
                S_DATA: if (accept) begin
                    mem_wdata <= {mem_wdata[23:0], byte_data};
                    byte_idx  <= byte_idx + 2'd1;
                end
                S_WRITE: begin
                    count <= count + 16'd1;
                    // Address stays on the last word written so DONE shows N-1.
                    if (!last_word) mem_addr <= mem_addr + ADDR_WIDTH'(1);
                end
                S_DONE: if (start) mem_addr <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: image loads, handshake gaps, bad headers,
// mid-load reset and reload after done.
module tb_prog_loader;

    localparam int AW = 10;

    logic          clk;
    logic          reset;
    logic          start;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          error;

    prog_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(1024)) dut (
        .clk(clk), .reset(reset), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_total = 0;
    int start_cyc = 0;
    int done_low = 0;

    logic [7:0]    stim[$];
    logic [AW-1:0] w_addr[$];
    logic [31:0]   w_data[$];
    int            w_acc[$];
    int            w_cyc[$];

    logic [31:0] img_words[3];
    initial img_words = '{32'h20020005, 32'h00421020, 32'h08000002};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we) begin
            w_addr.push_back(mem_addr);
            w_data.push_back(mem_wdata);
            w_acc.push_back(acc_total);
            w_cyc.push_back(cyc + 1);
        end
        if (!done) done_low++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        w_addr.delete();
        w_data.delete();
        w_acc.delete();
        w_cyc.delete();
    endtask

    task automatic load_img();
        stim = {8'h00, 8'h03, 8'h20, 8'h02, 8'h00, 8'h05,
                8'h00, 8'h42, 8'h10, 8'h20, 8'h08, 8'h00, 8'h00, 8'h02};
    endtask

    // Pulses start on the first cycle, then offers stim bytes until stop_after
    // have been accepted. Acceptance is sampled just before the rising edge.
    task automatic send(input bit toggle, input int spur_at, input int stop_after);
        int idx = 0;
        int n = 0;
        int want;
        want = (stim.size() < stop_after) ? stim.size() : stop_after;
        acc_total = 0;
        while (idx < want && n < 1000) begin
            @(negedge clk);
            start      = (n == 0) || (idx == spur_at);
            byte_valid = toggle ? (n % 2 == 0) : 1'b1;
            byte_data  = stim[idx];
            #4;
            if (n == 0) start_cyc = cyc + 1;
            if (byte_valid && byte_ready) begin
                idx++;
                acc_total++;
            end
            n++;
        end
        @(negedge clk);
        start      = 1'b0;
        byte_valid = 1'b0;
        check("bytes accepted", idx, want);
    endtask

    task automatic check_image(input string tag, input bit timing);
        check({tag, " write count"}, w_addr.size(), 3);
        for (int k = 0; k < 3 && k < w_addr.size(); k++) begin
            check({tag, " addr"}, w_addr[k], k);
            check({tag, " data"}, w_data[k], img_words[k]);
            check({tag, " bytes before write"}, w_acc[k], 2 + 4 * (k + 1));
            if (timing) check({tag, " write edge"}, w_cyc[k] - start_cyc, 5 * k + 7);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " byte_ready"}, byte_ready, 0);
        check({tag, " mem_we"}, mem_we, 0);
        check({tag, " mem_addr"}, mem_addr, 0);
        check({tag, " mem_wdata"}, mem_wdata, 0);
        check({tag, " cpu_hold"}, cpu_hold, 1);
        check({tag, " done"}, done, 0);
        check({tag, " error"}, error, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_vec %0d", n_vec);
        $fatal(1);
    end

    initial begin
        int extra;
        reset = 1'b1;
        start = 1'b0;
        byte_valid = 1'b0;
        byte_data = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("in reset");
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("after reset");

        // Three-word image, byte_valid held high.
        load_img();
        clear_log();
        send(1'b0, -1, 1000);
        repeat (2) @(negedge clk);
        check_image("steady", 1'b1);
        check("steady done", done, 1);
        check("steady cpu_hold", cpu_hold, 0);
        check("steady mem_addr", mem_addr, 2);
        check("steady error", error, 0);
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            byte_valid = 1'b1;
            byte_data  = 8'hAA;
            #4;
            if (byte_valid && byte_ready) extra++;
        end
        @(negedge clk);
        byte_valid = 1'b0;
        check("post-done accepts", extra, 0);
        check("post-done writes", w_addr.size(), 3);

        // Reload after done with a one-word image.
        stim = {8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        clear_log();
        #1 done_low = 0;
        send(1'b0, -1, 1000);
        repeat (2) @(negedge clk);
        check("reload write count", w_addr.size(), 1);
        if (w_addr.size() > 0) begin
            check("reload addr", w_addr[0], 0);
            check("reload data", w_data[0], 32'hDEADBEEF);
        end
        check("reload done-low cycles", done_low, 7);
        check("reload done", done, 1);
        check("reload mem_addr", mem_addr, 0);

        // Same image with byte_valid toggling every cycle.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        load_img();
        clear_log();
        send(1'b1, -1, 1000);
        repeat (2) @(negedge clk);
        check_image("toggle", 1'b0);
        check("toggle done", done, 1);

        // start asserted while in DATA must be ignored.
        load_img();
        clear_log();
        send(1'b0, 6, 1000);
        repeat (2) @(negedge clk);
        check_image("spurious start", 1'b1);
        check("spurious start done", done, 1);

        // Zero-length header.
        stim = {8'h00, 8'h00};
        clear_log();
        send(1'b0, -1, 1000);
        repeat (2) @(negedge clk);
        check("len0 error", error, 1);
        check("len0 cpu_hold", cpu_hold, 1);
        check("len0 done", done, 0);
        check("len0 byte_ready", byte_ready, 0);

        // Length one past the maximum, started from ERROR.
        stim = {8'h04, 8'h01};
        send(1'b0, -1, 1000);
        repeat (2) @(negedge clk);
        check("len1025 error", error, 1);
        check("len1025 cpu_hold", cpu_hold, 1);

        // Exactly the maximum length is accepted.
        stim = {8'h04, 8'h00};
        send(1'b0, -1, 1000);
        check("len1024 error", error, 0);
        check("len1024 byte_ready", byte_ready, 1);
        check("bad headers write count", w_addr.size(), 0);

        // Reset after two words and two bytes of the third.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        load_img();
        clear_log();
        send(1'b0, -1, 12);
        check("midload writes before reset", w_addr.size(), 2);
        #2 reset = 1'b1;
        #1 check_reset_outputs("midload reset");
        @(negedge clk);
        reset = 1'b0;
        clear_log();
        send(1'b0, -1, 1000);
        repeat (2) @(negedge clk);
        check_image("after midload reset", 1'b1);
        check("after midload reset done", done, 1);
        check("after midload reset mem_addr", mem_addr, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Hardware program loader for the single-cycle CPU. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and writes them sequentially into CPU memory starting at word address 0. It holds the CPU in reset until a complete image is written. It is the synthesizable counterpart of the simulation-time memory image load, sitting between an external byte source (UART receiver or bench driver) and the memory write port.

## Interface
- ADDR_WIDTH, 10: memory word-address width.
- MAX_WORDS, 1024: largest accepted image, in words; must be ≤ 2^ADDR_WIDTH.
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a load.
- byte_valid  input  1  source has a byte on byte_data.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader can accept a byte this cycle.
- mem_we  output  1  memory write strobe, one cycle per word.
- mem_addr  output  ADDR_WIDTH  word address of the current write.
- mem_wdata  output  32  word to write.
- cpu_hold  output  1  high keeps the CPU in reset.
- done  output  1  image loaded successfully; level.
- error  output  1  length header rejected; level.

## Operation
- Stream format: 2-byte length N (words), MSB first, then 4·N data bytes, each word MSB first.
- A byte transfers only on a rising edge where byte_valid && byte_ready. Bytes offered while byte_ready=0 are not consumed.
- States:
  - IDLE: byte_ready=0. start → LEN_HI.
  - LEN_HI: byte_ready=1. Accept byte → N[15:8], go to LEN_LO.
  - LEN_LO: byte_ready=1. Accept byte → N[7:0]. If the full N is 0 or > MAX_WORDS → ERROR, else → DATA with byte index 0 and mem_addr 0.
  - DATA: byte_ready=1. Each accepted byte shifts into mem_wdata from the LSB side, so the first byte lands in [31:24]. The 4th accepted byte → WRITE.
  - WRITE: byte_ready=0, mem_we=1 for exactly this cycle, mem_addr and mem_wdata stable. On exit, mem_addr increments and the word count increments. If count == N → DONE, else → DATA.
  - DONE: done=1, cpu_hold=0, byte_ready=0. start → LEN_HI, clearing done, setting cpu_hold, and zeroing mem_addr.
  - ERROR: error=1, cpu_hold=1, byte_ready=0. start → LEN_HI, clearing error.
- start is ignored in LEN_HI, LEN_LO, DATA and WRITE.
- cpu_hold = 1 in every state except DONE.
- mem_addr never wraps: N ≤ MAX_WORDS ≤ 2^ADDR_WIDTH, and the address is not incremented past the last write (it holds N-1 in DONE).
- Word count register is 16 bits. The byte index is 2 bits.

## Timing
- Reset values: state IDLE, byte_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, cpu_hold 1, done 0, error 0, N 0.
- Reset takes effect immediately at any point, including mid-load. No partial state survives. Memory contents already written are not undone.
- All outputs are registered or decoded from the registered state only. There is no combinational path from byte_valid or start to any output.
- Latency with byte_valid held high: start at edge t gives byte_ready=1 after t.
  - Header takes 2 cycles; each word takes 4 accept cycles plus 1 WRITE cycle.
  - The mem_we pulse for word k occurs 5k+7 cycles after the start edge, counting from k=0.
  - done rises in the cycle after the last WRITE.
- Gaps in byte_valid stall the FSM in its current state with no side effects.

## Test plan
- Reset, start, stream 00 03 | 20 02 00 05 | 00 42 10 20 | 08 00 00 02 → three mem_we pulses at addr 0,1,2 with data 20020005, 00421020, 08000002. Then done=1, cpu_hold=0, mem_addr=2, and no further bytes accepted.
- Same image with byte_valid toggling 1/0 every cycle → identical writes; each mem_we pulse still preceded by exactly 4 accepted bytes.
- Header 00 00 → error=1, cpu_hold=1, mem_we never asserted. Header 04 01 with MAX_WORDS=1024 → error=1.
- Assert reset after 2 of 3 words written and mid-word → all outputs return to reset values within the reset assertion. A following start plus the full image reloads from addr 0.
- After done, pulse start and stream 00 01 | DE AD BE EF → done drops for the load, a single write to addr 0 of DEADBEEF, then done=1.
- start pulsed during DATA → ignored; the byte index and address sequence are unchanged.
